// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared stall encodings, FSM states and helpers
// Purpose: single home for the stall-vector width, the five stall encodings
//          and the controller state codes used by pipeline_ctrl.
// Ports:   none (package).
package pipeline_ctrl_pkg;

  localparam int STALL_W = 5;

  // Bit order: [0] PC, [1] IF, [2] ID, [3] EX, [4] MEM.
  localparam logic [STALL_W-1:0] STALL_NONE = 5'b00000;
  localparam logic [STALL_W-1:0] STALL_IF   = 5'b00011;
  localparam logic [STALL_W-1:0] STALL_ID   = 5'b00111;
  localparam logic [STALL_W-1:0] STALL_EX   = 5'b01111;
  localparam logic [STALL_W-1:0] STALL_MEM  = 5'b11111;
  localparam logic [STALL_W-1:0] STALL_ALL  = 5'b11111;

  typedef enum logic [2:0] {
    ST_RUN        = 3'd0,
    ST_STALL      = 3'd1,
    ST_HALT       = 3'd2,
    ST_FLUSH_WAIT = 3'd3,
    ST_FLUSH      = 3'd4
  } state_t;

  // The deepest requesting stage wins: it must freeze itself and everything
  // upstream of it.
  function automatic logic [STALL_W-1:0] stall_encode(input logic mem,
                                                      input logic ex,
                                                      input logic id,
                                                      input logic fetch);
    logic [STALL_W-1:0] v;
    if (mem)        v = STALL_MEM;
    else if (ex)    v = STALL_EX;
    else if (id)    v = STALL_ID;
    else if (fetch) v = STALL_IF;
    else            v = STALL_NONE;
    return v;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// rtl/pipeline_ctrl_sat_counter.sv - saturating up-counter with synchronous clear
// Purpose: counts inc cycles, sticks at all-ones, never wraps; clr wins over inc.
// Ports:   clk, rst (async active-low), clr, inc -> count[WIDTH-1:0].
module pipeline_ctrl_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - pipeline stall/halt/flush controller with stall watchdog
// Purpose: turns per-stage stall requests, halt and flush/redirect into the
//          5-bit stall vector, a one-cycle flush pulse with redirect PC, and
//          stall statistics (total stall cycles, sticky consecutive-stall flag).
// Ports:   clk, rst (async active-low)
//          stall_req_if/id/ex/mem, halt_req, flush_req, flush_pc[31:0]  (in)
//          stall_o[4:0] (comb), flush_o, new_pc_o[31:0],
//          stall_cycles_o[15:0], stall_timeout_o (registered)          (out)
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned STALL_TIMEOUT = 1023
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_req_if,
  input  logic               stall_req_id,
  input  logic               stall_req_ex,
  input  logic               stall_req_mem,
  input  logic               halt_req,
  input  logic               flush_req,
  input  logic [31:0]        flush_pc,
  output logic [STALL_W-1:0] stall_o,
  output logic               flush_o,
  output logic [31:0]        new_pc_o,
  output logic [15:0]        stall_cycles_o,
  output logic               stall_timeout_o
);

  localparam logic [16:0] TIMEOUT_CMP = 17'(STALL_TIMEOUT);

  state_t             state_q;
  state_t             state_d;
  logic               capture;
  logic               any_req;
  logic [STALL_W-1:0] req_vec;
  logic               in_stall;
  logic [15:0]        consec_cnt;
  logic               timeout_hit;

  assign any_req = stall_req_if | stall_req_id | stall_req_ex | stall_req_mem;
  assign req_vec = stall_encode(stall_req_mem, stall_req_ex, stall_req_id, stall_req_if);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // RUN, STALL and HALT share one decision: HALT only persists because
  // halt_req is re-evaluated every cycle, exactly like in RUN/STALL.
  always_comb begin
    state_d = state_q;
    stall_o = STALL_NONE;
    capture = 1'b0;
    if (!rst) begin
      stall_o = STALL_NONE;
    end else begin
      case (state_q)
        ST_FLUSH_WAIT: begin
          stall_o = STALL_ALL;
          state_d = ST_FLUSH;
        end
        ST_FLUSH: begin
          stall_o = STALL_NONE;
          state_d = ST_RUN;
        end
        default: begin
          if (flush_req) begin
            stall_o = STALL_ALL;
            capture = 1'b1;
            state_d = ST_FLUSH_WAIT;
          end else if (halt_req) begin
            stall_o = STALL_ALL;
            state_d = ST_HALT;
          end else begin
            stall_o = req_vec;
            state_d = any_req ? ST_STALL : ST_RUN;
          end
        end
      endcase
    end
  end

  // flush_o is high exactly for the cycle spent in FLUSH, which always
  // follows FLUSH_WAIT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flush_o  <= 1'b0;
      new_pc_o <= 32'h0;
    end else begin
      flush_o <= (state_q == ST_FLUSH_WAIT);
      if (capture) begin
        new_pc_o <= flush_pc;
      end
    end
  end

  assign in_stall = (state_q == ST_STALL);

  pipeline_ctrl_sat_counter #(.WIDTH(16)) u_total_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (1'b0),
    .inc   (in_stall),
    .count (stall_cycles_o)
  );

  pipeline_ctrl_sat_counter #(.WIDTH(16)) u_consec_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (~in_stall),
    .inc   (in_stall),
    .count (consec_cnt)
  );

  // Compare against the value the counter takes on this edge so the flag
  // rises together with the counter reaching the limit. The 17-bit add keeps
  // a saturated counter from aliasing onto a small limit.
  assign timeout_hit = in_stall && (({1'b0, consec_cnt} + 17'd1) == TIMEOUT_CMP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_timeout_o <= 1'b0;
    end else if (state_q == ST_FLUSH_WAIT) begin
      stall_timeout_o <= 1'b0;
    end else if (timeout_hit) begin
      stall_timeout_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed self-checking bench for pipeline_ctrl
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_req_if, stall_req_id, stall_req_ex, stall_req_mem;
  logic        halt_req, flush_req;
  logic [31:0] flush_pc;
  logic [4:0]  stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic [15:0] stall_cycles_o;
  logic        stall_timeout_o;

  int n_checks = 0;
  int n_errors = 0;

  pipeline_ctrl #(.STALL_TIMEOUT(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall_req_if    (stall_req_if),
    .stall_req_id    (stall_req_id),
    .stall_req_ex    (stall_req_ex),
    .stall_req_mem   (stall_req_mem),
    .halt_req        (halt_req),
    .flush_req       (flush_req),
    .flush_pc        (flush_pc),
    .stall_o         (stall_o),
    .flush_o         (flush_o),
    .new_pc_o        (new_pc_o),
    .stall_cycles_o  (stall_cycles_o),
    .stall_timeout_o (stall_timeout_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs are then changed 2 time units after the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic reqs(input logic mem, input logic ex, input logic id, input logic fi);
    stall_req_mem = mem;
    stall_req_ex  = ex;
    stall_req_id  = id;
    stall_req_if  = fi;
  endtask

  initial begin
    rst = 1'b0;
    reqs(1, 1, 1, 1);
    halt_req  = 1'b1;
    flush_req = 1'b1;
    flush_pc  = 32'h1234_5678;
    repeat (3) @(posedge clk);
    #2;
    check("rst_stall_o", 32'(stall_o), 32'h0);
    check("rst_flush_o", 32'(flush_o), 32'h0);
    check("rst_new_pc", new_pc_o, 32'h0);
    check("rst_stall_cycles", 32'(stall_cycles_o), 32'h0);
    check("rst_timeout", 32'(stall_timeout_o), 32'h0);

    reqs(0, 0, 0, 0);
    halt_req  = 1'b0;
    flush_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("post_rst_stall_o", 32'(stall_o), 32'h0);
    tick();
    check("post_rst_flush_o", 32'(flush_o), 32'h0);

    // ex stall for three cycles; two STALL cycles plus the draining one count
    reqs(0, 1, 0, 0); settle();
    check("ex_c1", 32'(stall_o), 32'h0F);
    tick(); settle();
    check("ex_c2", 32'(stall_o), 32'h0F);
    tick(); settle();
    check("ex_c3", 32'(stall_o), 32'h0F);
    tick(); reqs(0, 0, 0, 0); settle();
    check("ex_release", 32'(stall_o), 32'h00);
    check("ex_cnt_mid", 32'(stall_cycles_o), 32'd2);
    tick();
    check("ex_cnt_after", 32'(stall_cycles_o), 32'd3);
    tick();
    check("ex_cnt_run_hold", 32'(stall_cycles_o), 32'd3);

    // id + mem, then drop mem in STALL
    reqs(1, 0, 1, 0); settle();
    check("id_mem", 32'(stall_o), 32'h1F);
    tick(); reqs(0, 0, 1, 0); settle();
    check("id_only", 32'(stall_o), 32'h07);
    tick(); reqs(0, 0, 0, 1); settle();
    check("if_only", 32'(stall_o), 32'h03);
    tick(); reqs(0, 0, 0, 0);
    tick();
    check("idmem_cnt", 32'(stall_cycles_o), 32'd6);

    // flush with ex stall; second redirect during FLUSH_WAIT is dropped
    reqs(0, 1, 0, 0); flush_req = 1'b1; flush_pc = 32'h0000_0380; settle();
    check("fl_n_stall", 32'(stall_o), 32'h1F);
    tick(); flush_pc = 32'hDEAD_0000; settle();
    check("fl_n1_stall", 32'(stall_o), 32'h1F);
    check("fl_n1_flush", 32'(flush_o), 32'h0);
    tick(); flush_req = 1'b0; settle();
    check("fl_n2_flush", 32'(flush_o), 32'h1);
    check("fl_n2_pc", new_pc_o, 32'h0000_0380);
    check("fl_n2_stall", 32'(stall_o), 32'h00);
    tick(); settle();
    check("fl_n3_stall", 32'(stall_o), 32'h0F);
    check("fl_n3_flush", 32'(flush_o), 32'h0);
    check("fl_n3_pc_hold", new_pc_o, 32'h0000_0380);
    reqs(0, 0, 0, 0);
    tick(); tick();

    // watchdog: STALL entered at the first edge; flag rises once 8 STALL
    // cycles have been counted, i.e. visible in the 10th request cycle
    for (int i = 1; i <= 10; i++) begin
      reqs(1, 0, 0, 0); settle();
      if (i == 9)  check("wd_before", 32'(stall_timeout_o), 32'h0);
      if (i == 10) check("wd_set", 32'(stall_timeout_o), 32'h1);
      tick();
    end
    reqs(0, 0, 0, 0);
    tick(); tick(); tick();
    check("wd_sticky", 32'(stall_timeout_o), 32'h1);
    flush_req = 1'b1; flush_pc = 32'h0000_0400;
    tick(); flush_req = 1'b0; settle();
    check("wd_fw_hold", 32'(stall_timeout_o), 32'h1);
    tick();
    check("wd_flush_clr", 32'(stall_timeout_o), 32'h0);
    check("wd_flush_pc", new_pc_o, 32'h0000_0400);
    tick();

    // reset during FLUSH_WAIT: no flush pulse after release
    flush_req = 1'b1; flush_pc = 32'h0000_0500;
    tick(); flush_req = 1'b0;
    rst = 1'b0; settle();
    check("midfl_rst_pc", new_pc_o, 32'h0);
    check("midfl_rst_cnt", 32'(stall_cycles_o), 32'h0);
    @(negedge clk); rst = 1'b1;
    tick();
    check("midfl_no_pulse_a", 32'(flush_o), 32'h0);
    tick();
    check("midfl_no_pulse_b", 32'(flush_o), 32'h0);

    // halt during id stall freezes counters
    reqs(0, 0, 1, 0);
    tick(); tick(); tick();
    halt_req = 1'b1; settle();
    check("halt_stall_o", 32'(stall_o), 32'h1F);
    tick();
    for (int i = 0; i < 4; i++) begin
      settle();
      check("halt_frozen_stall", 32'(stall_o), 32'h1F);
      check("halt_frozen_cnt", 32'(stall_cycles_o), 32'd3);
      tick();
    end
    halt_req = 1'b0;
    tick(); settle();
    check("halt_rel_stall", 32'(stall_o), 32'h07);
    check("halt_rel_cnt", 32'(stall_cycles_o), 32'd3);
    tick();
    check("halt_rel_cnt_inc", 32'(stall_cycles_o), 32'd4);

    repeat (70000) @(posedge clk);
    #2;
    check("sat_ffff", 32'(stall_cycles_o), 32'h0000_FFFF);
    tick();
    check("sat_hold", 32'(stall_cycles_o), 32'h0000_FFFF);

    rst = 1'b0; settle();
    check("final_rst_cnt", 32'(stall_cycles_o), 32'h0);
    check("final_rst_wd", 32'(stall_timeout_o), 32'h0);
    check("final_rst_stall", 32'(stall_o), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
